// File: rtl/viterbi_traceback.sv
// Survivor-path memory and traceback for the K=7 Viterbi decoder.
// Two banks of decisions; one frame is written while the other is traced and emitted.
module viterbi_traceback #(
    parameter logic [5:0] START_STATE = 6'd0
) (
    input  logic       CLOCK,
    input  logic       Reset,
    input  logic       Active,
    input  logic [5:0] ACSPage,
    input  logic [3:0] ACSSegment,
    input  logic [3:0] Decision,
    input  logic       TB_EN,
    output logic       DataOut,
    output logic       DataValid,
    output logic       FrameStart,
    output logic       Busy,
    output logic       Overrun
);

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        EMIT
    } state_t;

    state_t      state_q, state_d;
    logic        wr_bank_q, wr_bank_d;
    logic        tr_bank_q, tr_bank_d;
    logic [5:0]  s_q, s_d;
    logic [5:0]  page_q, page_d;
    logic [5:0]  idx_q, idx_d;
    logic [63:0] buf_q, buf_d;
    logic        dout_q, dout_d;
    logic        dval_q, dval_d;
    logic        fs_q, fs_d;
    logic        ovr_q, ovr_d;

    logic [63:0] mem_q [0:1][0:63];
    logic [63:0] rd_word;
    logic        dec_bit;
    logic        trig;

    // Survivor storage is deliberately left out of reset.
    always_ff @(posedge CLOCK) begin
        if (Active) begin
            mem_q[wr_bank_q][ACSPage][{ACSSegment, 2'b00} +: 4] <= Decision;
        end
    end

    assign rd_word = mem_q[tr_bank_q][page_q];
    assign dec_bit = rd_word[s_q];
    assign trig    = Active && (&ACSPage) && (&ACSSegment);

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        tr_bank_d = tr_bank_q;
        s_d       = s_q;
        page_d    = page_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        dout_d    = dout_q;
        dval_d    = 1'b0;
        fs_d      = 1'b0;
        ovr_d     = ovr_q;

        if (trig) begin
            wr_bank_d = ~wr_bank_q;
        end

        unique case (state_q)
            IDLE: begin
                if (trig && TB_EN) begin
                    tr_bank_d = wr_bank_q;
                    s_d       = START_STATE;
                    page_d    = 6'd63;
                    state_d   = TRACE;
                end
            end
            TRACE: begin
                buf_d[page_q] = s_q[5];
                s_d           = {s_q[4:0], dec_bit};
                page_d        = page_q - 6'd1;
                if (page_q == 6'd0) begin
                    idx_d   = 6'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                dout_d = buf_q[idx_q];
                dval_d = 1'b1;
                fs_d   = (idx_q == 6'd0);
                idx_d  = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame finishing while the previous one is still in flight is lost.
        if (trig && TB_EN && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            wr_bank_q <= 1'b0;
            tr_bank_q <= 1'b0;
            s_q       <= 6'd0;
            page_q    <= 6'd0;
            idx_q     <= 6'd0;
            buf_q     <= 64'd0;
            dout_q    <= 1'b0;
            dval_q    <= 1'b0;
            fs_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            tr_bank_q <= tr_bank_d;
            s_q       <= s_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            dout_q    <= dout_d;
            dval_q    <= dval_d;
            fs_q      <= fs_d;
            ovr_q     <= ovr_d;
        end
    end

    assign DataOut    = dout_q;
    assign DataValid  = dval_q;
    assign FrameStart = fs_q;
    assign Busy       = (state_q != IDLE);
    assign Overrun    = ovr_q;

endmodule
